sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit memory-stage loads/stores onto a 16-bit asynchronous SRAM as two half-word cycles.
// Optional feature macro SRAM_WAIT_STATES_EN adds WAIT_CYCLES idle cycles after the high half-word access.
module sram_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N
);

`ifdef SRAM_WAIT_STATES_EN
   typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;
   logic [15:0] waitCnt_q;
   logic [15:0] waitCnt_d;
`else
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   localparam int unusedWaitCycles = WAIT_CYCLES;
`endif

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        request;
   logic        isWrite_q;
   logic [16:0] addrIdx_q;
   logic [31:0] wdata_q;
   logic [31:0] readData_q;
   logic [31:0] offset;
   logic        inAccess;
   logic        driveDq;
   logic [15:0] dqOut;
   logic        unusedOffsetBits;

   assign request          = wr_en | rd_en;
   assign offset           = address - 32'(BASE_ADDR);
   assign unusedOffsetBits = ^{offset[31:19], offset[1:0]};

   // State register; a low rst at the edge abandons whatever access is in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
`ifdef SRAM_WAIT_STATES_EN
      waitCnt_d = waitCnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (request) begin
               accept  = 1'b1;
               state_d = LO;
            end
         end
         LO: state_d = HI;
         HI: begin
`ifdef SRAM_WAIT_STATES_EN
            waitCnt_d = 16'd0;
            state_d   = (WAIT_CYCLES == 0) ? DONE : WAIT;
`else
            state_d = DONE;
`endif
         end
`ifdef SRAM_WAIT_STATES_EN
         WAIT: begin
            if (waitCnt_q == 16'(WAIT_CYCLES - 1)) begin
               state_d = DONE;
            end else begin
               waitCnt_d = waitCnt_q + 16'd1;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef SRAM_WAIT_STATES_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         waitCnt_q <= 16'd0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end
`endif

   // Request latch plus read capture: low half lands at the end of LO, high half at the end of HI.
   always_ff @(posedge clk) begin
      if (!rst) begin
         isWrite_q  <= 1'b0;
         addrIdx_q  <= 17'd0;
         wdata_q    <= 32'd0;
         readData_q <= 32'd0;
      end else begin
         if (accept) begin
            isWrite_q <= wr_en;
            addrIdx_q <= offset[18:2];
            wdata_q   <= write_data;
         end
         if (state_q == LO && !isWrite_q) begin
            readData_q[15:0] <= SRAM_DQ;
         end
         if (state_q == HI && !isWrite_q) begin
            readData_q[31:16] <= SRAM_DQ;
         end
      end
   end

   assign inAccess = (state_q == LO) || (state_q == HI);
   assign driveDq  = inAccess && isWrite_q;
   assign dqOut    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
   assign SRAM_DQ  = driveDq ? dqOut : 16'bz;

   always_comb begin
      SRAM_ADDR = 18'd0;
      if (inAccess) begin
         SRAM_ADDR = {addrIdx_q, (state_q == HI)};
      end
   end

   assign SRAM_WE_N = ~driveDq;
   assign SRAM_OE_N = driveDq;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign read_data = readData_q;

   // During reset the controller looks idle, so ready depends only on the live request lines.
   always_comb begin
      ready = 1'b0;
      if (!rst || state_q == IDLE) begin
         ready = ~request;
      end else if (state_q == DONE) begin
         ready = 1'b1;
      end
   end

endmodule
